// File: rtl/fork_arb_pkg.sv
// Shared types and default sizing for the fork arbiter.
//   state_e    : broadcast FSM state (IDLE, BCAST)
//   DEF_WIDTH  : default packet width in bits
//   DEF_NREQ   : default requester count (legal 2..8)
//   DEF_NDEST  : default destination count (legal 2..8)
package fork_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 2;
  localparam int DEF_NDEST = 2;

endpackage

// File: rtl/fork_arbiter_rr.sv
// Round-robin search, purely combinational.
//   i_req    : request vector
//   i_ptr    : index with highest priority this cycle (must be < NREQ)
//   o_gnt    : one-hot grant, zero when no request is present
//   o_gnt_id : index of the granted bit (0 when nothing is granted)
module rr_arbiter
  import fork_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_id
);

  // Walk upward from i_ptr, wrapping at NREQ; the first set bit wins.
  // The wrap is done by subtraction so non-power-of-two NREQ works.
  always_comb begin
    logic           found;
    int             idx;
    logic [IDW-1:0] id;
    o_gnt    = '0;
    o_gnt_id = '0;
    found    = 1'b0;
    idx      = 0;
    id       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(i_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      id = IDW'(idx);
      if (!found && i_req[id]) begin
        found    = 1'b1;
        o_gnt[id] = 1'b1;
        o_gnt_id = id;
      end
    end
  end

endmodule

// File: rtl/fork_arbiter.sv
// Arbitrated fork: NREQ requesters share one broadcast path to NDEST
// destinations. One packet is in flight at a time; it is held until every
// destination has taken it exactly once.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_req_valid      : per-requester offer
//   i_req_data       : requester k packet at [k*WIDTH +: WIDTH]
//   o_req_ready      : one-hot acceptance (combinational, IDLE only)
//   o_dest_valid     : per-destination packet available
//   o_dest_data      : broadcast packet, common to all destinations
//   i_dest_ready     : per-destination acceptance (ignored outside BCAST)
//   o_grant_id       : requester whose packet is/was last in flight
//   o_busy           : broadcast in progress
module fork_arbiter
  import fork_arb_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  parameter  int NDEST = DEF_NDEST,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [NDEST-1:0]      o_dest_valid,
  output logic [WIDTH-1:0]      o_dest_data,
  input  logic [NDEST-1:0]      i_dest_ready,
  output logic [IDW-1:0]        o_grant_id,
  output logic                  o_busy
);

  state_e           r_state, w_nxt_state;
  logic [NDEST-1:0] r_pend,  w_nxt_pend, w_done;
  logic [IDW-1:0]   r_ptr,   w_nxt_ptr;
  logic [IDW-1:0]   r_gid,   w_nxt_gid;
  logic [WIDTH-1:0] r_data,  w_nxt_data;
  logic [NREQ-1:0]  w_win;
  logic [IDW-1:0]   w_win_id;
  logic [WIDTH-1:0] w_win_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_win),
    .o_gnt_id (w_win_id)
  );

  assign w_win_data = i_req_data[int'(w_win_id)*WIDTH +: WIDTH];

  // Per-destination handshake; several may complete in the same cycle.
  for (genvar d = 0; d < NDEST; d++) begin : g_dst
    assign w_done[d] = r_pend[d] & i_dest_ready[d];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_pend  <= w_nxt_pend;
      r_ptr   <= w_nxt_ptr;
      r_gid   <= w_nxt_gid;
      r_data  <= w_nxt_data;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_pend   = r_pend;
    w_nxt_ptr    = r_ptr;
    w_nxt_gid    = r_gid;
    w_nxt_data   = r_data;
    o_req_ready  = '0;
    o_dest_valid = '0;
    o_dest_data  = '0;
    o_busy       = 1'b0;

    case (r_state)
      IDLE: begin
        if (|i_req_valid) begin
          o_req_ready = w_win;
          w_nxt_data  = w_win_data;
          w_nxt_gid   = w_win_id;
          w_nxt_ptr   = (w_win_id == IDW'(NREQ-1)) ? '0 : w_win_id + IDW'(1);
          w_nxt_pend  = '1;
          w_nxt_state = BCAST;
        end
      end
      BCAST: begin
        o_busy       = 1'b1;
        o_dest_valid = r_pend;
        o_dest_data  = r_data;
        w_nxt_pend   = r_pend & ~w_done;
        // Return to IDLE once the last destination is served; the next
        // grant is evaluated only in IDLE, so it lands a cycle later.
        if (w_nxt_pend == '0) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase

    // Reset is synchronous, so state is still live in the reset cycle;
    // mask the handshake outputs so nothing leaks while it is asserted.
    if (i_rst) begin
      o_req_ready  = '0;
      o_dest_valid = '0;
      o_dest_data  = '0;
      o_busy       = 1'b0;
    end
  end

  assign o_grant_id = r_gid;

endmodule

// File: tb/tb_fork_arbiter.sv
module tb_fork_arbiter;
  import fork_arb_pkg::*;

  localparam int W   = 4;
  localparam int NR  = 2;
  localparam int ND  = 2;
  localparam int NR4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default-size instance
  logic [NR-1:0]   rv, rr;
  logic [NR*W-1:0] rd;
  logic [ND-1:0]   dv, dr;
  logic [W-1:0]    dd;
  logic [0:0]      gid;
  logic            busy;

  // NREQ=4 instance
  logic [NR4-1:0]   rv4, rr4;
  logic [NR4*W-1:0] rd4;
  logic [ND-1:0]    dv4, dr4;
  logic [W-1:0]     dd4;
  logic [1:0]       gid4;
  logic             busy4;

  fork_arbiter #(.WIDTH(W), .NREQ(NR), .NDEST(ND)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(rv), .i_req_data(rd), .o_req_ready(rr),
    .o_dest_valid(dv), .o_dest_data(dd), .i_dest_ready(dr),
    .o_grant_id(gid), .o_busy(busy)
  );

  fork_arbiter #(.WIDTH(W), .NREQ(NR4), .NDEST(ND)) u_dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(rv4), .i_req_data(rd4), .o_req_ready(rr4),
    .o_dest_valid(dv4), .o_dest_data(dd4), .i_dest_ready(dr4),
    .o_grant_id(gid4), .o_busy(busy4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t exp4_q[$];

  task automatic push(input logic [1:0] id, input logic [W-1:0] data);
    pkt_t p;
    p.id = id; p.data = data;
    exp_q.push_back(p);
  endtask

  task automatic push4(input logic [1:0] id, input logic [W-1:0] data);
    pkt_t p;
    p.id = id; p.data = data;
    exp4_q.push_back(p);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor, default instance: pops on each broadcast start,
  // checks data stays put, and counts deliveries per destination.
  initial begin
    pkt_t       p;
    int         cnt [ND];
    logic       prev;
    logic [W-1:0] hold;
    prev = 1'b0;
    hold = '0;
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        for (int d = 0; d < ND; d++) cnt[d] = 0;
      end else begin
        if (rr != '0) begin
          chk("rdy_onehot", 32'($onehot(rr)), 1);
          chk("rdy_not_busy", busy, 0);
        end
        if (busy && !prev) begin
          chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            chk("sb_gid", gid, p.id);
            chk("sb_data", dd, p.data);
          end
          hold = dd;
        end
        if (busy) chk("data_hold", dd, hold);
        for (int d = 0; d < ND; d++) cnt[d] += int'(dv[d] & dr[d]);
        if (!busy && prev) begin
          for (int d = 0; d < ND; d++) begin
            chk("deliver_once", cnt[d], 1);
            cnt[d] = 0;
          end
        end
        prev = busy;
      end
    end
  end

  // Scoreboard monitor, NREQ=4 instance.
  initial begin
    pkt_t p;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (busy4 && !prev) begin
          chk("sb4_nonempty", 32'(exp4_q.size() != 0), 1);
          if (exp4_q.size() != 0) begin
            p = exp4_q.pop_front();
            chk("sb4_gid", gid4, p.id);
            chk("sb4_data", dd4, p.data);
          end
        end
        prev = busy4;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [1:0] t2_dr [5] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
  logic [1:0] t2_dv [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
  logic       t2_bz [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    rv = '0; rd = '0; dr = '0;
    rv4 = '0; rd4 = '0; dr4 = '0;

    // reset: outputs masked even with a request present
    repeat (2) @(posedge clk);
    #1; rv = 2'b01; rd = 8'h0A;
    smp();
    chk("rst_rdy", rr, 0);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dd", dd, 0);
    cyc(); rst = 1'b0; rv = '0;
    smp();
    chk("post_rst_rdy", rr, 0);
    chk("post_rst_dv", dv, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_dd", dd, 0);
    chk("post_rst_gid", gid, 0);

    // single requester, both destinations ready
    cyc(); rv = 2'b01; rd = 8'h0A; dr = 2'b11; push(0, 4'hA);
    smp(); chk("t1_rdy", rr, 2'b01); chk("t1_busy0", busy, 0);
    cyc(); rv = '0;
    smp(); chk("t1_dv", dv, 2'b11); chk("t1_dd", dd, 4'hA);
    chk("t1_busy1", busy, 1); chk("t1_rdy_bc", rr, 0); chk("t1_gid", gid, 0);
    cyc();
    smp(); chk("t1_idle_busy", busy, 0); chk("t1_idle_dv", dv, 0);

    // staggered destinations
    cyc(); rv = 2'b01; rd = 8'h06; dr = 2'b00; push(0, 4'h6);
    smp(); chk("t2_rdy", rr, 2'b01);
    for (int i = 0; i < 5; i++) begin
      cyc(); rv = '0; dr = t2_dr[i];
      smp(); chk("t2_dv", dv, t2_dv[i]); chk("t2_busy", busy, t2_bz[i]);
    end

    // contention on the default instance, fairness on the NREQ=4 one
    cyc(); rst = 1'b1;
    smp();
    cyc(); rst = 1'b0;
    cyc(); rv = 2'b11; rd = 8'h53; dr = 2'b11;
    push(0, 4'h3); push(1, 4'h5); push(0, 4'h3); push(1, 4'h5);
    rv4 = 4'b1001; rd4 = 16'h9001; dr4 = 2'b11;
    push4(0, 4'h1); push4(3, 4'h9); push4(0, 4'h1);
    push4(3, 4'h9); push4(0, 4'h1); push4(3, 4'h9);
    for (int i = 0; i < 60 && (exp_q.size() > 0 || exp4_q.size() > 0); i++) begin
      cyc();
      if (exp_q.size() == 0)  rv  = '0;
      if (exp4_q.size() == 0) rv4 = '0;
    end
    rv = '0; rv4 = '0;
    chk("t3_drain", exp_q.size(), 0);
    chk("t4_drain", exp4_q.size(), 0);
    cyc(); smp(); chk("t3_idle", busy, 0); chk("t4_idle", busy4, 0);

    // reset mid-broadcast with dest1 still pending
    cyc(); rv = 2'b01; rd = 8'h07; dr = 2'b00; push(0, 4'h7);
    smp(); chk("t5_rdy", rr, 2'b01);
    cyc(); rv = '0; dr = 2'b01;
    smp(); chk("t5_dv11", dv, 2'b11);
    cyc(); dr = 2'b00;
    smp(); chk("t5_dv10", dv, 2'b10);
    cyc(); rst = 1'b1;
    smp(); chk("t5_rst_dv", dv, 0); chk("t5_rst_busy", busy, 0);
    cyc(); rst = 1'b0; rv = 2'b11; rd = 8'hC2; dr = 2'b11; push(0, 4'h2);
    smp(); chk("t5_dv_after", dv, 0); chk("t5_busy_after", busy, 0);
    chk("t5_ptr0", rr, 2'b01);
    cyc(); rv = '0;
    smp(); chk("t5_dv_pkt", dv, 2'b11);
    cyc(); rv = 2'b10; push(1, 4'hC);
    smp(); chk("t5_rdy1", rr, 2'b10);
    cyc(); rv = '0;
    smp(); chk("t5_gid1", gid, 1); chk("t5_dd1", dd, 4'hC);
    cyc();

    // dest_ready high in IDLE with no requests
    for (int i = 0; i < 3; i++) begin
      cyc(); dr = 2'b11;
      smp(); chk("t6_dv", dv, 0); chk("t6_busy", busy, 0);
      chk("t6_rdy", rr, 0); chk("t6_gid", gid, 1); chk("t6_dd", dd, 0);
    end
    cyc(); rv = 2'b11; rd = 8'h94; push(0, 4'h4);
    smp(); chk("t6_rdy_req", rr, 2'b01);
    cyc(); rv = '0;
    smp(); chk("t6_dv_req", dv, 2'b11);
    cyc();
    smp(); chk("t6_end", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("sb4_empty", exp4_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
